// File: rtl/tile_wr_arbiter.sv
// Two-requester round-robin write arbiter for the tile RAM, with an optional whole-table fill engine.
// The fill engine is compiled in only when TILE_WR_ARBITER_FILL_EN is defined.
module tile_wr_arbiter #(
    parameter int ROWS       = 30,
    parameter int COLS       = 40,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din
);
    localparam int unsigned           DEPTH     = ROWS * COLS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic                  ack0_q, ack1_q, err0_q, err1_q, we_q, prio_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  elig0, elig1, gnt0, gnt1, oor0, oor1, arb_en;

    // A port acked this cycle sits out the next edge, so it cannot be granted twice for one request.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;
    // prio_q names the port that wins a tie; it moves to the other port after every grant.
    assign gnt0  = elig0 & (~elig1 | ~prio_q);
    assign gnt1  = elig1 & (~elig0 |  prio_q);
    assign oor0  = 32'(addr0) >= DEPTH;
    assign oor1  = 32'(addr1) >= DEPTH;

`ifdef TILE_WR_ARBITER_FILL_EN
    typedef enum logic {IDLE, FILL} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fval_q;
    logic                  busy_q, done_q;

    assign cnt_d     = (cnt_q == LAST_ADDR) ? cnt_q : cnt_q + ADDR_WIDTH'(1);
    // A fill start sampled in IDLE takes the edge; requests wait until the fill is over.
    assign arb_en    = (state_q == IDLE) & ~fill_start;
    assign fill_busy = busy_q;
    assign fill_done = done_q;
`else
    logic unused_fill;

    assign unused_fill = ^{fill_start, fill_value};
    assign arb_en      = 1'b1;
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            prio_q  <= 1'b0;
`ifdef TILE_WR_ARBITER_FILL_EN
            state_q <= IDLE;
            cnt_q   <= '0;
            fval_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            we_q   <= 1'b0;
`ifdef TILE_WR_ARBITER_FILL_EN
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        state_q <= FILL;
                        cnt_q   <= '0;
                        fval_q  <= fill_value;
                        we_q    <= 1'b1;
                        waddr_q <= '0;
                        din_q   <= fill_value;
                        busy_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_d;
                        we_q    <= 1'b1;
                        waddr_q <= cnt_d;
                        din_q   <= fval_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
`endif
            if (arb_en && gnt0) begin
                ack0_q <= 1'b1;
                err0_q <= oor0;
                prio_q <= 1'b1;
                if (!oor0) begin
                    we_q    <= 1'b1;
                    waddr_q <= addr0;
                    din_q   <= data0;
                end
            end else if (arb_en && gnt1) begin
                ack1_q <= 1'b1;
                err1_q <= oor1;
                prio_q <= 1'b0;
                if (!oor1) begin
                    we_q    <= 1'b1;
                    waddr_q <= addr1;
                    din_q   <= data1;
                end
            end
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign ram_we    = we_q;
    assign ram_waddr = waddr_q;
    assign ram_din   = din_q;
endmodule

// File: tb/tb_tile_wr_arbiter.sv
// Randomized scoreboard bench for tile_wr_arbiter: a transaction-level model queues expected
// output events, and a negedge monitor pops one whenever the DUT shows any activity.
`timescale 1ns/1ps
module tb_tile_wr_arbiter;
    localparam int ROWS  = 30;
    localparam int COLS  = 40;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = ROWS * COLS;
`ifdef TILE_WR_ARBITER_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] din;
        logic          a0, a1, e0, e1, busy, done;
    } rec_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_value = '0;
    logic          ack0, ack1, err0, err1, fill_busy, fill_done, ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;

    int   n_vec = 0, n_mis = 0;
    rec_t exp_q[$];
    rec_t act_r, exp_r;

    always #5 clk = ~clk;

    tile_wr_arbiter #(.ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: per sampled edge, decide which single event the next cycle must show.
    int            m_last = 1;
    logic [1:0]    m_ackd = '0;
    bit            m_fill = 0;
    int            m_faddr = 0;
    logic [DW-1:0] m_fval = '0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_din = '0;

    task automatic model_step();
        rec_t r;
        int g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit e0, e1;
        r = '0;
        if (rst) begin
            m_last = 1; m_ackd = '0; m_fill = 0; m_faddr = 0; m_waddr = '0; m_din = '0;
            return;
        end
        if (!m_fill && FILL_EN && fill_start) begin
            m_fill = 1; m_fval = fill_value; m_faddr = 0;
        end
        if (m_fill) begin
            m_ackd = '0;
            if (m_faddr == DEPTH) begin
                m_fill = 0;
                r.done = 1'b1;
            end else begin
                m_waddr = AW'(m_faddr); m_din = m_fval;
                r.we = 1'b1; r.busy = 1'b1;
                m_faddr++;
            end
            r.waddr = m_waddr; r.din = m_din;
            exp_q.push_back(r);
            return;
        end
        e0 = req0 && !m_ackd[0];
        e1 = req1 && !m_ackd[1];
        g = -1;
        if (e0 && e1) g = (m_last == 0) ? 1 : 0;
        else if (e0) g = 0;
        else if (e1) g = 1;
        m_ackd = '0;
        if (g < 0) return;
        m_ackd[g] = 1'b1;
        m_last = g;
        a = (g == 0) ? addr0 : addr1;
        d = (g == 0) ? data0 : data1;
        if (g == 0) r.a0 = 1'b1; else r.a1 = 1'b1;
        if (int'(a) >= DEPTH) begin
            if (g == 0) r.e0 = 1'b1; else r.e1 = 1'b1;
        end else begin
            m_waddr = a; m_din = d; r.we = 1'b1;
        end
        r.waddr = m_waddr; r.din = m_din;
        exp_q.push_back(r);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (ram_we | ack0 | ack1 | err0 | err1 | fill_busy | fill_done) begin
            act_r.we = ram_we; act_r.waddr = ram_waddr; act_r.din = ram_din;
            act_r.a0 = ack0; act_r.a1 = ack1; act_r.e0 = err0; act_r.e1 = err1;
            act_r.busy = fill_busy; act_r.done = fill_done;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_event @%0t: got %h expected no activity", $time, act_r);
            end else begin
                exp_r = exp_q.pop_front();
                if (act_r !== exp_r) begin
                    n_mis++;
                    $display("FAIL txn @%0t: got %h expected %h (we,waddr,din,ack0,ack1,err0,err1,busy,done)",
                             $time, act_r, exp_r);
                end
            end
        end
    end

    // Requester drivers
    bit act_p[2];
    bit lazy_p[2];
    int wait_p[2];
    int oor_pct = 0;

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = 1'b1; addr0 = a; data0 = d; end
        else        begin req1 = 1'b1; addr1 = a; data1 = d; end
        act_p[p] = 1; wait_p[p] = 0;
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        act_p[p] = 0;
    endtask

    task automatic new_req(input int p);
        logic [AW-1:0] a;
        if ($urandom_range(0, 99) < oor_pct) a = AW'($urandom_range(DEPTH, (1 << AW) - 1));
        else a = AW'($urandom_range(0, DEPTH - 1));
        set_req(p, a, DW'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // after_mode: 0 drop on ack, 1 hold one cycle past ack, 2 new request at once, 3 random
    task automatic run_cycles(input int n, input int start_pct, input int after_mode, input int fill_pm);
        for (int c = 0; c < n; c++) begin
            tick();
            fill_start = 1'b0;
            for (int p = 0; p < 2; p++) begin
                bit ak;
                int m;
                ak = (p == 0) ? ack0 : ack1;
                m  = (after_mode == 3) ? int'($urandom_range(0, 2)) : after_mode;
                if (lazy_p[p]) begin
                    lazy_p[p] = 0;
                    drop(p);
                end else if (act_p[p] && ak) begin
                    if (m == 0) drop(p);
                    else if (m == 1) lazy_p[p] = 1;
                    else new_req(p);
                end else if (act_p[p]) begin
                    wait_p[p]++;
                    if (wait_p[p] > 3000) begin
                        n_vec++; n_mis++;
                        $display("FAIL ack_timeout: port %0d got no ack, expected one within 3000 cycles", p);
                        drop(p);
                    end
                end else if ($urandom_range(0, 99) < start_pct) begin
                    new_req(p);
                end
            end
            if (fill_pm > 0 && $urandom_range(0, 999) < fill_pm) begin
                fill_start = 1'b1;
                fill_value = DW'($urandom);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack0"}, 32'(ack0), 0);
        chk({tag, "_ack1"}, 32'(ack1), 0);
        chk({tag, "_err0"}, 32'(err0), 0);
        chk({tag, "_err1"}, 32'(err1), 0);
        chk({tag, "_ram_we"}, 32'(ram_we), 0);
        chk({tag, "_ram_waddr"}, 32'(ram_waddr), 0);
        chk({tag, "_ram_din"}, 32'(ram_din), 0);
        chk({tag, "_fill_busy"}, 32'(fill_busy), 0);
        chk({tag, "_fill_done"}, 32'(fill_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin act_p[i] = 0; lazy_p[i] = 0; wait_p[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single request held one cycle past its ack: exactly one write.
        set_req(0, 11'd5, 8'h1A);
        run_cycles(6, 0, 1, 0);

        // Out-of-range address.
        set_req(1, 11'd1200, 8'h77);
        run_cycles(4, 0, 0, 0);

        // Continuous contention with valid addresses: grants alternate every cycle.
        set_req(0, 11'd10, 8'h01);
        set_req(1, 11'd11, 8'h02);
        run_cycles(20, 0, 2, 0);
        run_cycles(6, 0, 0, 0);

`ifdef TILE_WR_ARBITER_FILL_EN
        // Fill wins over a simultaneous request; the request is served after fill_done.
        set_req(0, 11'd9, 8'h3C);
        fill_value = 8'h00;
        fill_start = 1'b1;
        run_cycles(DEPTH + 10, 0, 0, 0);

        // Reset in the middle of a fill.
        fill_value = 8'hA5;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        begin
            int k;
            k = 0;
            while (!(ram_we && ram_waddr == 11'd600) && k < 1000) begin tick(); k++; end
            chk("reach_addr_600", 32'(ram_waddr), 600);
        end
        rst = 1'b1;
        tick();
        check_zero("mid_fill_reset");
        rst = 1'b0;
        run_cycles(DEPTH + 100, 0, 0, 0);
        fill_value = 8'h5E;
        fill_start = 1'b1;
        run_cycles(DEPTH + 10, 0, 0, 0);
`else
        // Fill disabled: fill_start has no effect, requests are served normally.
        fill_value = 8'h55;
        fill_start = 1'b1;
        set_req(0, 11'd20, 8'h99);
        tick();
        fill_start = 1'b0;
        chk("nofill_busy", 32'(fill_busy), 0);
        chk("nofill_ack0", 32'(ack0), 1);
        run_cycles(6, 0, 0, 0);
`endif

        // Random traffic with occasional fill pulses.
        oor_pct = 12;
        run_cycles(3000, 35, 3, 1);
        oor_pct = 0;
        run_cycles(DEPTH + 200, 0, 0, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
